snn_inference_ctrl: RTL and testbench

- Sequences one inference window of the 8-3-10 LIF spiking network: clears neuron and counter state, gates input current for a programmable number of timesteps, then drains the pipeline.
- After draining, scans the 10 output spike counts serially and reports the winning class (argmax).
- Sits between the top-level pin interface and the LIF layers / spike-counter readout; the network's only sequencing authority.

---
 rtl/snn_inference_ctrl_pkg.sv | 17 +
 rtl/snn_inference_ctrl_if.sv | 27 ++
 rtl/snn_inference_ctrl_argmax_scan.sv | 41 ++++
 rtl/snn_inference_ctrl.sv | 134 +++++++++++++
 tb/tb_snn_inference_ctrl.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snn_inference_ctrl_pkg.sv
// Shared types and sizing constants for the 8-3-10 LIF inference controller.
package snn_pkg;

    localparam int unsigned NUM_CLASSES = 10;
    localparam int unsigned WIDTH_P     = 8;
    localparam int unsigned IDX_W       = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_SCAN,
        S_DONE
    } state_e;

endpackage

// File: rtl/snn_inference_ctrl_if.sv
// Host-side command/result interface of the inference controller.
interface snn_inference_ctrl_if #(
    parameter int unsigned STEP_W  = 8,
    parameter int unsigned WIDTH_P = snn_pkg::WIDTH_P,
    parameter int unsigned IDX_W   = snn_pkg::IDX_W
) ();

    logic               start_i;
    logic               abort_i;
    logic [STEP_W-1:0]  steps_i;
    logic               busy_o;
    logic               result_valid_o;
    logic [IDX_W-1:0]   class_o;
    logic [WIDTH_P-1:0] max_count_o;
    logic               saturated_o;

    modport master (
        output start_i, abort_i, steps_i,
        input  busy_o, result_valid_o, class_o, max_count_o, saturated_o
    );

    modport slave (
        input  start_i, abort_i, steps_i,
        output busy_o, result_valid_o, class_o, max_count_o, saturated_o
    );

endinterface

// File: rtl/snn_inference_ctrl_argmax_scan.sv
// Serial argmax over the spike counts, one class per step; ties keep the lowest index.
module snn_argmax_scan
    import snn_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [IDX_W-1:0]   idx_i,
    input  logic [WIDTH_P-1:0] count_i,
    output logic [WIDTH_P-1:0] best_o,
    output logic [IDX_W-1:0]   best_idx_o,
    output logic               sat_o
);

    logic [WIDTH_P-1:0] best_q;
    logic [IDX_W-1:0]   best_idx_q;
    logic               sat_q;
    logic               take;

    // Outputs already fold in the current count so the final step's result is usable same cycle.
    always_comb begin
        take       = load_i || (count_i > best_q);
        best_o     = take ? count_i : best_q;
        best_idx_o = take ? idx_i : best_idx_q;
        sat_o      = (count_i == '1) || (sat_q && !load_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            best_q     <= '0;
            best_idx_q <= '0;
            sat_q      <= 1'b0;
        end else if (step_i) begin
            best_q     <= best_o;
            best_idx_q <= best_idx_o;
            sat_q      <= sat_o;
        end
    end

endmodule

// File: rtl/snn_inference_ctrl.sv
// Inference window sequencer: clear, gated run, pipeline drain, argmax scan, result.
module snn_inference_ctrl
    import snn_pkg::*;
#(
    parameter int unsigned STEP_W       = 8,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    snn_inference_ctrl_if.slave            host,
    input  logic [NUM_CLASSES*WIDTH_P-1:0] spike_counts_i,
    output logic                           net_clear_o,
    output logic                           net_en_o,
    output logic                           input_gate_o
);

    state_e             state_q;
    logic [STEP_W-1:0]  steps_q;
    logic [STEP_W-1:0]  cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic               net_clear_q, net_en_q, gate_q, valid_q, sat_q;
    logic [IDX_W-1:0]   class_q;
    logic [WIDTH_P-1:0] max_q;
    logic [WIDTH_P-1:0] cur_count;
    logic [WIDTH_P-1:0] scan_best;
    logic [IDX_W-1:0]   scan_idx;
    logic               scan_sat;

    always_comb begin
        cur_count = '0;
        for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
            if (idx_q == IDX_W'(k)) cur_count = spike_counts_i[k*WIDTH_P +: WIDTH_P];
        end
    end

    snn_argmax_scan u_scan (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (idx_q == '0),
        .step_i     (state_q == S_SCAN),
        .idx_i      (idx_q),
        .count_i    (cur_count),
        .best_o     (scan_best),
        .best_idx_o (scan_idx),
        .sat_o      (scan_sat)
    );

    // Outputs are assigned alongside the state they belong to, so they line up with state_q.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            steps_q     <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            net_clear_q <= 1'b0;
            net_en_q    <= 1'b0;
            gate_q      <= 1'b0;
            valid_q     <= 1'b0;
            class_q     <= '0;
            max_q       <= '0;
            sat_q       <= 1'b0;
        end else if (host.abort_i && state_q != S_IDLE) begin
            state_q     <= S_IDLE;
            net_clear_q <= 1'b0;
            net_en_q    <= 1'b0;
            gate_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            net_clear_q <= 1'b0;
            valid_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (host.start_i && !host.abort_i) begin
                        state_q     <= S_CLEAR;
                        steps_q     <= host.steps_i;
                        net_clear_q <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    cnt_q    <= '0;
                    net_en_q <= 1'b1;
                    if (steps_q == '0) begin
                        state_q <= S_DRAIN;
                    end else begin
                        state_q <= S_RUN;
                        gate_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (cnt_q == steps_q - 1'b1) begin
                        state_q <= S_DRAIN;
                        cnt_q   <= '0;
                        gate_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (cnt_q == STEP_W'(DRAIN_CYCLES - 1)) begin
                        state_q  <= S_SCAN;
                        idx_q    <= '0;
                        net_en_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_SCAN: begin
                    if (idx_q == IDX_W'(NUM_CLASSES - 1)) begin
                        state_q <= S_DONE;
                        valid_q <= 1'b1;
                        class_q <= scan_idx;
                        max_q   <= scan_best;
                        sat_q   <= scan_sat;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign net_clear_o         = net_clear_q;
    assign net_en_o            = net_en_q;
    assign input_gate_o        = gate_q;
    assign host.busy_o         = (state_q != S_IDLE);
    assign host.result_valid_o = valid_q;
    assign host.class_o        = class_q;
    assign host.max_count_o    = max_q;
    assign host.saturated_o    = sat_q;

endmodule

// File: tb/tb_snn_inference_ctrl.sv
// Directed bench for snn_inference_ctrl with hand-computed expectations.
module tb_snn_inference_ctrl;
    import snn_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic [NUM_CLASSES*WIDTH_P-1:0] counts;
    logic net_clear, net_en, gate;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    snn_inference_ctrl_if #(.STEP_W(8), .WIDTH_P(WIDTH_P), .IDX_W(IDX_W)) ifc ();

    snn_inference_ctrl #(.STEP_W(8), .DRAIN_CYCLES(3)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .host           (ifc.slave),
        .spike_counts_i (counts),
        .net_clear_o    (net_clear),
        .net_en_o       (net_en),
        .input_gate_o   (gate)
    );

    task automatic set_cnt(input int v[10]);
        for (int k = 0; k < 10; k++) counts[k*8 +: 8] = v[k][7:0];
    endtask

    // Starts one inference and samples every cycle until result_valid_o (lat = -1 on timeout).
    task automatic run_inf(input logic [7:0] s, output int lat, output int nclr,
                           output int ngate, output int nen);
        lat = -1; nclr = 0; ngate = 0; nen = 0;
        @(negedge clk);
        ifc.steps_i = s;
        ifc.start_i = 1'b1;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            @(negedge clk);
            ifc.start_i = 1'b0;
            nclr  += int'(net_clear);
            ngate += int'(gate);
            nen   += int'(net_en);
            if (ifc.result_valid_o) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({ifc.busy_o, ifc.result_valid_o, net_clear, net_en, gate} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 00000",
                     {ifc.busy_o, ifc.result_valid_o, net_clear, net_en, gate});
        end
        checks++;
        if ({ifc.class_o, ifc.max_count_o, ifc.saturated_o} !== 13'b0) begin
            errors++;
            $display("FAIL reset_result: class=%0d max=%0d sat=%b required 0/0/0",
                     ifc.class_o, ifc.max_count_o, ifc.saturated_o);
        end
    endtask

    task automatic test_basic();
        int lat, nclr, ngate, nen;
        set_cnt('{0, 10, 20, 30, 40, 50, 60, 70, 80, 90});
        run_inf(8'd4, lat, nclr, ngate, nen);
        checks++;
        if (lat !== 19) begin errors++; $display("FAIL basic_latency: got %0d required 19", lat); end
        checks++;
        if (nclr !== 1) begin errors++; $display("FAIL basic_clear_cycles: got %0d required 1", nclr); end
        checks++;
        if (ngate !== 4) begin errors++; $display("FAIL basic_gate_cycles: got %0d required 4", ngate); end
        checks++;
        if (nen !== 7) begin errors++; $display("FAIL basic_en_cycles: got %0d required 7", nen); end
        checks++;
        if (ifc.class_o !== 4'd9 || ifc.max_count_o !== 8'd90 || ifc.saturated_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: class=%0d max=%0d sat=%b required 9/90/0",
                     ifc.class_o, ifc.max_count_o, ifc.saturated_o);
        end
        checks++;
        if (ifc.busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy_done: got %b required 1", ifc.busy_o); end
        @(negedge clk);
        checks++;
        if (ifc.busy_o !== 1'b0 || ifc.result_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_after_done: busy=%b valid=%b required 0/0", ifc.busy_o, ifc.result_valid_o);
        end
    endtask

    task automatic test_ties();
        int lat, nclr, ngate, nen;
        set_cnt('{5, 20, 20, 3, 0, 0, 0, 0, 0, 0});
        run_inf(8'd2, lat, nclr, ngate, nen);
        checks++;
        if (lat !== 17) begin errors++; $display("FAIL ties_latency: got %0d required 17", lat); end
        checks++;
        if (ifc.class_o !== 4'd1 || ifc.max_count_o !== 8'd20) begin
            errors++;
            $display("FAIL ties_result: class=%0d max=%0d required 1/20", ifc.class_o, ifc.max_count_o);
        end
    endtask

    task automatic test_zero();
        int lat, nclr, ngate, nen;
        set_cnt('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        run_inf(8'd1, lat, nclr, ngate, nen);
        checks++;
        if (lat !== 16 || ifc.class_o !== 4'd0 || ifc.max_count_o !== 8'd0 || ifc.saturated_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_result: lat=%0d class=%0d max=%0d sat=%b required 16/0/0/0",
                     lat, ifc.class_o, ifc.max_count_o, ifc.saturated_o);
        end
    endtask

    task automatic test_steps_zero();
        int lat, nclr, ngate, nen;
        set_cnt('{0, 10, 20, 30, 40, 50, 60, 70, 80, 90});
        run_inf(8'd0, lat, nclr, ngate, nen);
        checks++;
        if (lat !== 15) begin errors++; $display("FAIL steps0_latency: got %0d required 15", lat); end
        checks++;
        if (ngate !== 0 || nen !== 3 || nclr !== 1) begin
            errors++;
            $display("FAIL steps0_enables: gate=%0d en=%0d clr=%0d required 0/3/1", ngate, nen, nclr);
        end
        checks++;
        if (ifc.class_o !== 4'd9 || ifc.max_count_o !== 8'd90) begin
            errors++;
            $display("FAIL steps0_result: class=%0d max=%0d required 9/90", ifc.class_o, ifc.max_count_o);
        end
    endtask

    task automatic test_saturated();
        int lat, nclr, ngate, nen;
        set_cnt('{1, 2, 3, 4, 5, 6, 255, 7, 100, 9});
        run_inf(8'd3, lat, nclr, ngate, nen);
        checks++;
        if (lat !== 18 || ifc.class_o !== 4'd6 || ifc.max_count_o !== 8'd255 || ifc.saturated_o !== 1'b1) begin
            errors++;
            $display("FAIL sat_result: lat=%0d class=%0d max=%0d sat=%b required 18/6/255/1",
                     lat, ifc.class_o, ifc.max_count_o, ifc.saturated_o);
        end
    endtask

    task automatic test_abort();
        int nvalid = 0;
        int gate_seen;
        set_cnt('{0, 10, 20, 30, 40, 50, 60, 70, 80, 90});
        @(negedge clk);
        ifc.steps_i = 8'd5;
        ifc.start_i = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            @(posedge clk);
            @(negedge clk);
            ifc.start_i = 1'b0;
        end
        gate_seen = int'(gate);
        ifc.abort_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.abort_i = 1'b0;
        checks++;
        if (gate_seen !== 1) begin errors++; $display("FAIL abort_in_run: gate=%0d required 1", gate_seen); end
        checks++;
        if (ifc.busy_o !== 1'b0 || net_en !== 1'b0 || gate !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b en=%b gate=%b required 0/0/0", ifc.busy_o, net_en, gate);
        end
        for (int n = 0; n < 30; n++) begin
            @(posedge clk);
            @(negedge clk);
            nvalid += int'(ifc.result_valid_o);
        end
        checks++;
        if (nvalid !== 0 || ifc.class_o !== 4'd6 || ifc.max_count_o !== 8'd255 || ifc.saturated_o !== 1'b1) begin
            errors++;
            $display("FAIL abort_retain: valids=%0d class=%0d max=%0d sat=%b required 0/6/255/1",
                     nvalid, ifc.class_o, ifc.max_count_o, ifc.saturated_o);
        end
        ifc.start_i = 1'b1;
        ifc.abort_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.start_i = 1'b0;
        ifc.abort_i = 1'b0;
        checks++;
        if (ifc.busy_o !== 1'b0 || net_clear !== 1'b0) begin
            errors++;
            $display("FAIL abort_beats_start: busy=%b clear=%b required 0/0", ifc.busy_o, net_clear);
        end
    endtask

    task automatic test_start_during_scan();
        int lat = -1;
        int extra_valid = 0;
        int extra_busy = 0;
        set_cnt('{10, 10, 10, 77, 10, 10, 10, 10, 10, 10});
        @(negedge clk);
        ifc.steps_i = 8'd0;
        ifc.start_i = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            @(negedge clk);
            ifc.start_i = (n == 8);
            if (ifc.result_valid_o) begin
                lat = n;
                break;
            end
        end
        ifc.start_i = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            extra_valid += int'(ifc.result_valid_o);
            extra_busy  += int'(ifc.busy_o);
        end
        checks++;
        if (lat !== 15 || ifc.class_o !== 4'd3 || ifc.max_count_o !== 8'd77) begin
            errors++;
            $display("FAIL scan_start_result: lat=%0d class=%0d max=%0d required 15/3/77",
                     lat, ifc.class_o, ifc.max_count_o);
        end
        checks++;
        if (extra_valid !== 0 || extra_busy !== 0) begin
            errors++;
            $display("FAIL scan_start_ignored: valids=%0d busy_cycles=%0d required 0/0", extra_valid, extra_busy);
        end
    endtask

    task automatic test_steps_max();
        int lat, nclr, ngate, nen;
        set_cnt('{0, 10, 20, 30, 40, 250, 60, 70, 80, 90});
        run_inf(8'd255, lat, nclr, ngate, nen);
        checks++;
        if (lat !== 270 || ngate !== 255 || nen !== 258) begin
            errors++;
            $display("FAIL steps255: lat=%0d gate=%0d en=%0d required 270/255/258", lat, ngate, nen);
        end
        checks++;
        if (ifc.class_o !== 4'd5 || ifc.max_count_o !== 8'd250) begin
            errors++;
            $display("FAIL steps255_result: class=%0d max=%0d required 5/250", ifc.class_o, ifc.max_count_o);
        end
    endtask

    task automatic test_reset_mid_scan();
        set_cnt('{0, 10, 20, 30, 40, 50, 60, 70, 80, 90});
        @(negedge clk);
        ifc.steps_i = 8'd0;
        ifc.start_i = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk);
            @(negedge clk);
            ifc.start_i = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({ifc.busy_o, ifc.result_valid_o, net_clear, net_en, gate} !== 5'b0 ||
            {ifc.class_o, ifc.max_count_o, ifc.saturated_o} !== 13'b0) begin
            errors++;
            $display("FAIL reset_mid_scan: ctrl=%b class=%0d max=%0d sat=%b required all 0",
                     {ifc.busy_o, ifc.result_valid_o, net_clear, net_en, gate},
                     ifc.class_o, ifc.max_count_o, ifc.saturated_o);
        end
    endtask

    initial begin
        rst = 1'b1;
        ifc.start_i = 1'b0;
        ifc.abort_i = 1'b0;
        ifc.steps_i = '0;
        counts = '0;
        test_reset();
        test_basic();
        test_ties();
        test_zero();
        test_steps_zero();
        test_saturated();
        test_abort();
        test_start_during_scan();
        test_steps_max();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
